// File: rtl/mm2x2_pkg.sv
// rtl/mm2x2_pkg.sv - shared types and constants for the 2x2 matrix-multiply core
package mm2x2_pkg;

  // Default operand width and result width (room for the sum of two W x W products)
  localparam int W_DEF  = 4;
  localparam int RW_DEF = 2 * W_DEF + 1;

  // Eight operands are loaded (A then B), four results are produced
  localparam int N_ELEM = 8;
  localparam int N_RES  = 4;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mm2x2_mac.sv
// rtl/mm2x2_mac.sv - single shared multiply-accumulate unit with registered accumulator
module mm2x2_mac
  import mm2x2_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clr_acc,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [RW-1:0] acc
);

  logic [2*W-1:0] w_prod;
  logic [RW-1:0]  w_prod_ext;

  assign w_prod     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign w_prod_ext = {{(RW - 2 * W){1'b0}}, w_prod};

  // Start a new sum on clr_acc, otherwise add the product to the running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (ena) begin
      acc <= clr_acc ? w_prod_ext : acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/mm2x2_seq_core.sv
// rtl/mm2x2_seq_core.sv - sequential 2x2 unsigned matrix multiply: stream in, 8-step MAC, stream out
module mm2x2_seq_core
  import mm2x2_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [1:0]    out_idx,
  output logic          busy
);

  state_t        r_state;
  logic [2:0]    r_load_cnt;
  logic [2:0]    r_step;
  logic [W-1:0]  r_op [N_ELEM];
  logic [RW-1:0] r_res [N_RES];
  logic          r_wr_pend;
  logic [1:0]    r_wr_idx;
  logic          r_out_valid;
  logic [RW-1:0] r_out_data;
  logic [1:0]    r_out_idx;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_mac_ena;
  logic          w_clr_acc;
  logic [W-1:0]  w_mac_a;
  logic [W-1:0]  w_mac_b;
  logic [RW-1:0] w_acc;
  logic [1:0]    w_next_idx;

  assign in_ready  = (r_state == ST_LOAD) & ena;
  assign w_in_hs   = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready & ena;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign busy      = (r_state != ST_LOAD);

  // Step k: i=k[2], j=k[1], t=k[0]; A[i][t] lives at 2i+t, B[t][j] at 4+2t+j
  assign w_mac_a    = r_op[{1'b0, r_step[2], r_step[0]}];
  assign w_mac_b    = r_op[{1'b1, r_step[0], r_step[1]}];
  assign w_clr_acc  = ~r_step[0];
  assign w_mac_ena  = ena & (r_state == ST_COMPUTE);
  assign w_next_idx = r_out_idx + 2'd1;

  mm2x2_mac #(
    .W  (W),
    .RW (RW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (w_mac_ena),
    .clr_acc (w_clr_acc),
    .a       (w_mac_a),
    .b       (w_mac_b),
    .acc     (w_acc)
  );

  // Control FSM, operand/result storage and registered output stream.
  // The accumulator is registered, so a finished sum (t=1 step) is copied into
  // its result register one enabled cycle later via r_wr_pend. C11 therefore
  // lands in the first OUTPUT cycle, well before the idx-2 handshake reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LOAD;
      r_load_cnt  <= '0;
      r_step      <= '0;
      r_wr_pend   <= 1'b0;
      r_wr_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      for (int i = 0; i < N_ELEM; i++) r_op[i] <= '0;
      for (int i = 0; i < N_RES; i++) r_res[i] <= '0;
    end else if (ena) begin
      r_wr_pend <= (r_state == ST_COMPUTE) & r_step[0];
      r_wr_idx  <= r_step[2:1];
      if (r_wr_pend) begin
        r_res[r_wr_idx] <= w_acc;
      end

      if (clear) begin
        // Abort wins over any handshake in the same cycle
        r_state     <= ST_LOAD;
        r_load_cnt  <= '0;
        r_step      <= '0;
        r_out_valid <= 1'b0;
        r_out_idx   <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_in_hs) begin
              r_op[r_load_cnt] <= in_data;
              r_load_cnt       <= r_load_cnt + 3'd1;
              if (r_load_cnt == 3'd7) begin
                r_state <= ST_COMPUTE;
                r_step  <= '0;
              end
            end
          end
          ST_COMPUTE: begin
            r_step <= r_step + 3'd1;
            if (r_step == 3'd7) begin
              r_state     <= ST_OUTPUT;
              r_out_valid <= 1'b1;
              r_out_idx   <= '0;
              r_out_data  <= r_res[0];
            end
          end
          ST_OUTPUT: begin
            if (w_out_hs) begin
              r_out_idx  <= w_next_idx;
              r_out_data <= r_res[w_next_idx];
              if (r_out_idx == 2'd3) begin
                r_out_valid <= 1'b0;
                r_state     <= ST_LOAD;
              end
            end
          end
          default: begin
            r_state <= ST_LOAD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mm2x2_seq_core.sv
// tb/tb_mm2x2_seq_core.sv - randomized self-checking bench for mm2x2_seq_core
module tb_mm2x2_seq_core;

  localparam int W  = 4;
  localparam int RW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ma [4];
  int mb [4];
  int exp_c [4];

  mm2x2_seq_core #(.W(W), .RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // C[i][j] = sum over t of A[i][t] * B[t][j], row-major 2x2
  task automatic compute_ref();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        exp_c[i*2+j] = ma[i*2] * mb[j] + ma[i*2+1] * mb[2+j];
  endtask

  task automatic set_mats(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    ma[0] = a0; ma[1] = a1; ma[2] = a2; ma[3] = a3;
    mb[0] = b0; mb[1] = b1; mb[2] = b2; mb[3] = b3;
    compute_ref();
  endtask

  task automatic rand_mats();
    for (int k = 0; k < 4; k++) begin
      ma[k] = int'($urandom_range(0, 15));
      mb[k] = int'($urandom_range(0, 15));
    end
    compute_ref();
  endtask

  // Present the first n elements; returns just before the edge accepting the last one
  task automatic load_elems(input int n, input bit gap);
    int guard;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      forever begin
        @(negedge clk);
        in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = in_valid ? W'((k < 4) ? ma[k] : mb[k-4]) : W'($urandom);
        #1;
        guard++;
        if (in_valid && in_ready) break;
        if (guard > 60) begin
          chk("load_handshake", {31'd0, in_ready}, 32'd1);
          break;
        end
      end
    end
  endtask

  // Count enabled-or-not edges from the B11 accept edge until out_valid is seen
  task automatic wait_result(input bit ena_gap, input bit junk);
    int lat;
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_in_compute", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (ena_gap && lat == 2) begin
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("ena_low_out_valid", {31'd0, out_valid}, 32'd0);
        end
        ena = 1'b1;
        lat += 3;
      end
      if (junk) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
        #1;
        chk("in_ready_compute", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, ena_gap ? 32'd11 : 32'd8);
  endtask

  task automatic read_results(input int stall_idx, input int stall_n, input int clr_idx);
    for (int idx = 0; idx < 4; idx++) begin
      chk("out_valid", {31'd0, out_valid}, 32'd1);
      chk("out_idx", {30'd0, out_idx}, idx);
      chk("out_data", {23'd0, out_data}, exp_c[idx]);
      if (idx == clr_idx) begin
        clear     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd0);
        chk("clear_in_ready", {31'd0, in_ready}, 32'd1);
        return;
      end
      if (idx == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = W'($urandom);
          #1;
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_data", {23'd0, out_data}, exp_c[idx]);
          chk("stall_idx", {30'd0, out_idx}, idx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("done_out_valid", {31'd0, out_valid}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_ena0", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {23'd0, out_data}, 32'd0);
    chk("rst_out_idx", {30'd0, out_idx}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    ena = 1'b1;
    #1;
    chk("rst_in_ready_ena1", {31'd0, in_ready}, 32'd1);

    // Basic multiply
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, -1);

    // Max values
    set_mats(15, 15, 15, 15, 15, 15, 15, 15);
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, -1);

    // Backpressure at idx 1 and ena drop during COMPUTE
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_elems(8, 1'b0);
    wait_result(1'b1, 1'b0);
    read_results(1, 5, -1);

    // Gapped input with junk during COMPUTE
    rand_mats();
    load_elems(8, 1'b1);
    wait_result(1'b0, 1'b1);
    read_results(2, 2, -1);

    // clear after 5 elements, then identity A reload
    rand_mats();
    load_elems(5, 1'b0);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = W'($urandom);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_load_busy", {31'd0, busy}, 32'd0);
    set_mats(1, 0, 0, 1, 5, 6, 7, 8);
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, -1);

    // clear together with the idx 2 output handshake, then a normal run
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, 2);
    rand_mats();
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, -1);

    // Async reset mid-COMPUTE, between clock edges
    rand_mats();
    load_elems(8, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    set_mats(1, 2, 3, 4, 5, 6, 7, 8);
    load_elems(8, 1'b0);
    wait_result(1'b0, 1'b0);
    read_results(-1, 0, -1);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      rand_mats();
      load_elems(8, (r % 2) == 1);
      wait_result(r == 3, (r % 4) >= 2);
      read_results(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
